// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: FSM encoding and default vectors.
package interrupt_controller_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [31:0] DEF_IRQ_VEC_BASE = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE   = 32'h0000_0010;
  localparam logic [31:0] DEF_NMI_VECTOR   = 32'h0000_0080;

  // Handler address of a maskable line; overflow simply wraps at 32 bits.
  function automatic logic [31:0] irq_vector(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [2:0]  id);
    return base + 32'(id) * stride;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bundle between the peripherals/control unit (master) and the interrupt controller (slave).
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               nmi_in;
  logic               hold_in;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               int_ack;
  logic               eoi;
  logic               interrupt;
  logic               nmint;
  logic [31:0]        vector;
  logic [2:0]         active_id;
  logic               in_service;
  logic [NUM_IRQ-1:0] pending;

  // Handshake: interrupt/nmint act as "valid" and stay high with a stable vector
  // until int_ack ("ready") is sampled high on a clock edge; int_ack without an
  // outstanding request and eoi without a handler in service are ignored.
  modport master (
    output irq_in, nmi_in, hold_in, mask_we, mask_wdata, int_ack, eoi,
    input  interrupt, nmint, vector, active_id, in_service, pending
  );

  modport slave (
    input  irq_in, nmi_in, hold_in, mask_we, mask_wdata, int_ack, eoi,
    output interrupt, nmint, vector, active_id, in_service, pending
  );
endinterface

// File: rtl/irq_priority_enc.sv
// Lowest-index-first priority encoder over the eligible maskable lines.
module irq_priority_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [2:0]         idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan downwards so the last hit, the lowest index, wins.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched interrupt controller: one NMI plus NUM_IRQ maskable lines,
// a single registered request to the control unit and one handler in service.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int                 NUM_IRQ      = 4,
  parameter logic [31:0]        IRQ_VEC_BASE = DEF_IRQ_VEC_BASE,
  parameter logic [31:0]        VEC_STRIDE   = DEF_VEC_STRIDE,
  parameter logic [31:0]        NMI_VECTOR   = DEF_NMI_VECTOR,
  parameter logic [NUM_IRQ-1:0] MASK_RESET   = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_controller_if.slave bus,
  output logic [1:0]            state_o
);

  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, pending_q, pending_d, mask_q, mask_d;
  logic               nmi_q, nmi_pend_q, nmi_pend_d;
  logic               sel_nmi_q, sel_nmi_d;
  logic               interrupt_q, interrupt_d, nmint_q, nmint_d;
  logic [31:0]        vector_q, vector_d;
  logic [2:0]         active_id_q, active_id_d;
  logic               in_service_q, in_service_d;

  logic [NUM_IRQ-1:0] irq_rise, eligible, sel_onehot, pend_clr;
  logic               nmi_rise, nmi_clr, enc_valid;
  logic [2:0]         enc_idx;

  irq_priority_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
    .req_i   (eligible),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  always_comb begin
    irq_rise     = bus.irq_in & ~irq_q;
    nmi_rise     = bus.nmi_in & ~nmi_q;
    eligible     = bus.hold_in ? '0 : (pending_q & ~mask_q);
    sel_onehot   = NUM_IRQ'(1) << active_id_q;
    state_d      = state_q;
    sel_nmi_d    = sel_nmi_q;
    interrupt_d  = interrupt_q;
    nmint_d      = nmint_q;
    vector_d     = vector_q;
    active_id_d  = active_id_q;
    in_service_d = in_service_q;
    pend_clr     = '0;
    nmi_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (nmi_pend_q) begin
          state_d     = ST_REQ;
          sel_nmi_d   = 1'b1;
          nmint_d     = 1'b1;
          interrupt_d = 1'b0;
          vector_d    = NMI_VECTOR;
        end else if (enc_valid) begin
          state_d     = ST_REQ;
          sel_nmi_d   = 1'b0;
          interrupt_d = 1'b1;
          active_id_d = enc_idx;
          vector_d    = irq_vector(IRQ_VEC_BASE, VEC_STRIDE, enc_idx);
        end
      end
      ST_REQ: begin
        // Ack beats an NMI upgrade; an upgrade beats withdrawal.
        if (bus.int_ack) begin
          state_d      = ST_SERVICE;
          interrupt_d  = 1'b0;
          nmint_d      = 1'b0;
          in_service_d = 1'b1;
          if (sel_nmi_q) nmi_clr = 1'b1;
          else           pend_clr = sel_onehot;
        end else if (!sel_nmi_q && nmi_pend_q) begin
          sel_nmi_d   = 1'b1;
          nmint_d     = 1'b1;
          interrupt_d = 1'b0;
          vector_d    = NMI_VECTOR;
        end else if (!sel_nmi_q && (bus.hold_in || |(mask_q & sel_onehot))) begin
          state_d     = ST_IDLE;
          interrupt_d = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (bus.eoi) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh rising edge survives a clear of the same bit.
    pending_d  = (pending_q & ~pend_clr) | irq_rise;
    nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_rise;
    mask_d     = bus.mask_we ? bus.mask_wdata : mask_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      irq_q        <= '0;
      nmi_q        <= 1'b0;
      pending_q    <= '0;
      nmi_pend_q   <= 1'b0;
      mask_q       <= MASK_RESET;
      sel_nmi_q    <= 1'b0;
      interrupt_q  <= 1'b0;
      nmint_q      <= 1'b0;
      vector_q     <= '0;
      active_id_q  <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_q        <= bus.irq_in;
      nmi_q        <= bus.nmi_in;
      pending_q    <= pending_d;
      nmi_pend_q   <= nmi_pend_d;
      mask_q       <= mask_d;
      sel_nmi_q    <= sel_nmi_d;
      interrupt_q  <= interrupt_d;
      nmint_q      <= nmint_d;
      vector_q     <= vector_d;
      active_id_q  <= active_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign bus.interrupt  = interrupt_q;
  assign bus.nmint      = nmint_q;
  assign bus.vector     = vector_q;
  assign bus.active_id  = active_id_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: vector table with a scoreboard queue
// followed by hand-written multi-cycle sequences.
module tb_interrupt_controller;

  localparam int W = 42;  // {interrupt, nmint, vector[31:0], active_id[2:0], in_service, pending[3:0]}

  typedef struct {
    logic [3:0]   irq;
    logic         nmi;
    logic         hold;
    logic         mask_we;
    logic [3:0]   mask_wdata;
    logic         ack;
    logic         eoi;
    logic [W-1:0] exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         n_checks;
  int         n_pass;
  logic [W-1:0] exp_q[$];
  vec_t       tbl[16];

  interrupt_controller_if #(.NUM_IRQ(4)) bus ();

  interrupt_controller #(.NUM_IRQ(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(input logic i_int, input logic i_nmi, input logic [31:0] i_vec,
                                        input logic [2:0] i_id, input logic i_is, input logic [3:0] i_pend);
    return {i_int, i_nmi, i_vec, i_id, i_is, i_pend};
  endfunction

  function automatic logic [W-1:0] snap();
    return {bus.interrupt, bus.nmint, bus.vector, bus.active_id, bus.in_service, bus.pending};
  endfunction

  function automatic vec_t mk(input logic [3:0] irq, input logic nmi, input logic hold, input logic mwe,
                              input logic [3:0] mwd, input logic ack, input logic eoi,
                              input logic [W-1:0] exp);
    vec_t v;
    v.irq = irq; v.nmi = nmi; v.hold = hold; v.mask_we = mwe;
    v.mask_wdata = mwd; v.ack = ack; v.eoi = eoi; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [3:0] irq, input logic nmi, input logic hold, input logic ack, input logic eoi);
    bus.irq_in  = irq;
    bus.nmi_in  = nmi;
    bus.hold_in = hold;
    bus.mask_we = 1'b0;
    bus.int_ack = ack;
    bus.eoi     = eoi;
    step();
  endtask

  task automatic wr_mask(input logic [3:0] wdata);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = wdata;
    bus.int_ack    = 1'b0;
    bus.eoi        = 1'b0;
    step();
    bus.mask_we    = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.irq_in     = v.irq;
    bus.nmi_in     = v.nmi;
    bus.hold_in    = v.hold;
    bus.mask_we    = v.mask_we;
    bus.mask_wdata = v.mask_wdata;
    bus.int_ack    = v.ack;
    bus.eoi        = v.eoi;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    n_checks = 0;
    n_pass   = 0;

    // Irq 2 alone, then irqs 1 and 3 together, then stray eoi/ack in IDLE.
    tbl[0]  = mk(4'b0000, 0, 0, 1, 4'b0000, 0, 0, pack(0, 0, 32'h0,   3'd0, 0, 4'b0000));
    tbl[1]  = mk(4'b0100, 0, 0, 0, 4'b0000, 0, 0, pack(0, 0, 32'h0,   3'd0, 0, 4'b0100));
    tbl[2]  = mk(4'b0100, 0, 0, 0, 4'b0000, 0, 0, pack(1, 0, 32'h120, 3'd2, 0, 4'b0100));
    tbl[3]  = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 0, pack(0, 0, 32'h120, 3'd2, 1, 4'b0000));
    tbl[4]  = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 1, pack(0, 0, 32'h120, 3'd2, 0, 4'b0000));
    tbl[5]  = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, pack(0, 0, 32'h120, 3'd2, 0, 4'b0000));
    tbl[6]  = mk(4'b1010, 0, 0, 0, 4'b0000, 0, 0, pack(0, 0, 32'h120, 3'd2, 0, 4'b1010));
    tbl[7]  = mk(4'b1010, 0, 0, 0, 4'b0000, 0, 0, pack(1, 0, 32'h110, 3'd1, 0, 4'b1010));
    tbl[8]  = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 0, pack(0, 0, 32'h110, 3'd1, 1, 4'b1000));
    tbl[9]  = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, pack(0, 0, 32'h110, 3'd1, 1, 4'b1000));
    tbl[10] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 1, pack(0, 0, 32'h110, 3'd1, 0, 4'b1000));
    tbl[11] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 0, pack(1, 0, 32'h130, 3'd3, 0, 4'b1000));
    tbl[12] = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 0, pack(0, 0, 32'h130, 3'd3, 1, 4'b0000));
    tbl[13] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 1, pack(0, 0, 32'h130, 3'd3, 0, 4'b0000));
    tbl[14] = mk(4'b0000, 0, 0, 0, 4'b0000, 0, 1, pack(0, 0, 32'h130, 3'd3, 0, 4'b0000));
    tbl[15] = mk(4'b0000, 0, 0, 0, 4'b0000, 1, 0, pack(0, 0, 32'h130, 3'd3, 0, 4'b0000));

    // Reset
    rst = 1'b1;
    bus.irq_in = '0; bus.nmi_in = 1'b0; bus.hold_in = 1'b0; bus.mask_we = 1'b0;
    bus.mask_wdata = '0; bus.int_ack = 1'b0; bus.eoi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(snap()), 64'(pack(0, 0, 32'h0, 3'd0, 0, 4'b0000)));
    chk("reset_state", 64'(state), 64'(2'd0));
    rst = 1'b0;

    // Table with scoreboard
    for (int i = 0; i < 16; i++) begin
      apply_vec(tbl[i]);
      exp_q.push_back(tbl[i].exp);
      step();
      got = snap();
      exp = exp_q.pop_front();
      chk($sformatf("vec[%0d]", i), 64'(got), 64'(exp));
    end
    cyc(4'b0000, 0, 0, 0, 0);

    // NMI upgrade while line 0 is requested
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    chk("nmi_pre_int", 64'(bus.interrupt), 64'(1));
    chk("nmi_pre_vec", 64'(bus.vector), 64'h100);
    cyc(4'b0000, 1, 0, 0, 0);
    cyc(4'b0000, 1, 0, 0, 0);
    chk("nmi_up_nmint", 64'(bus.nmint), 64'(1));
    chk("nmi_up_int", 64'(bus.interrupt), 64'(0));
    chk("nmi_up_vec", 64'(bus.vector), 64'h80);
    cyc(4'b0000, 0, 0, 1, 0);
    chk("nmi_ack_is", 64'(bus.in_service), 64'(1));
    chk("nmi_ack_pend", 64'(bus.pending), 64'(4'b0001));
    chk("nmi_ack_nmint", 64'(bus.nmint), 64'(0));
    cyc(4'b0000, 0, 0, 0, 1);
    chk("nmi_eoi_is", 64'(bus.in_service), 64'(0));
    cyc(4'b0000, 0, 0, 0, 0);
    chk("nmi_after_int", 64'(bus.interrupt), 64'(1));
    chk("nmi_after_vec", 64'(bus.vector), 64'h100);
    cyc(4'b0000, 0, 0, 1, 0);
    cyc(4'b0000, 0, 0, 0, 1);

    // Mask, unmask, hold withdrawal, NMI under hold
    wr_mask(4'b0001);
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    chk("masked_int", 64'(bus.interrupt), 64'(0));
    chk("masked_pend", 64'(bus.pending), 64'(4'b0001));
    wr_mask(4'b0000);
    chk("unmask_1cyc", 64'(bus.interrupt), 64'(0));
    cyc(4'b0000, 0, 0, 0, 0);
    chk("unmask_2cyc", 64'(bus.interrupt), 64'(1));
    cyc(4'b0000, 0, 1, 0, 0);
    chk("hold_withdraw", 64'(bus.interrupt), 64'(0));
    chk("hold_pend", 64'(bus.pending), 64'(4'b0001));
    cyc(4'b0000, 1, 1, 0, 0);
    cyc(4'b0000, 1, 1, 0, 0);
    chk("hold_nmint", 64'(bus.nmint), 64'(1));
    chk("hold_nmi_vec", 64'(bus.vector), 64'h80);
    cyc(4'b0000, 0, 1, 1, 0);
    chk("hold_nmi_is", 64'(bus.in_service), 64'(1));
    cyc(4'b0000, 0, 1, 0, 1);
    cyc(4'b0000, 0, 1, 0, 0);
    chk("hold_blocks", 64'(bus.interrupt), 64'(0));
    cyc(4'b0000, 0, 0, 0, 0);
    chk("hold_release", 64'(bus.interrupt), 64'(1));
    cyc(4'b0000, 0, 0, 1, 0);
    cyc(4'b0000, 0, 0, 0, 1);

    // Set/clear collision on line 2
    cyc(4'b0100, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    chk("coll_req_id", 64'(bus.active_id), 64'(3'd2));
    cyc(4'b0100, 0, 0, 1, 0);
    chk("coll_pend", 64'(bus.pending), 64'(4'b0100));
    chk("coll_is", 64'(bus.in_service), 64'(1));
    cyc(4'b0000, 0, 0, 0, 1);
    cyc(4'b0000, 0, 0, 0, 0);
    chk("coll_rereq", 64'(bus.interrupt), 64'(1));
    chk("coll_rereq_vec", 64'(bus.vector), 64'h120);
    cyc(4'b0000, 0, 0, 1, 0);
    cyc(4'b0000, 0, 0, 0, 1);

    // Reset during SERVICE with an NMI pending
    cyc(4'b0010, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 1, 0);
    cyc(4'b0000, 1, 0, 0, 0);
    chk("pre_rst_is", 64'(bus.in_service), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 64'(snap()), 64'(pack(0, 0, 32'h0, 3'd0, 0, 4'b0000)));
    chk("async_rst_state", 64'(state), 64'(2'd0));
    bus.nmi_in = 1'b0;
    #2 rst = 1'b0;
    cyc(4'b0000, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    chk("post_rst_nmint", 64'(bus.nmint), 64'(0));
    chk("post_rst_int", 64'(bus.interrupt), 64'(0));
    cyc(4'b0001, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    cyc(4'b0000, 0, 0, 0, 0);
    chk("post_rst_masked", 64'(bus.interrupt), 64'(0));
    chk("post_rst_pend", 64'(bus.pending), 64'(4'b0001));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects external maskable interrupt lines and one non-maskable line, latches them as pending, and prioritises them.
- Presents a single request (interrupt or nmint) plus a vector address to the multi-cycle control unit.
- Holds one interrupt in service until end-of-interrupt (EOI). No nesting.
- Sits between peripherals and the control unit; the vector feeds the PCSrc=3 path.

Parameters:
- NUM_IRQ, 4: number of maskable lines (1..8).
- IRQ_VEC_BASE, 32'h0000_0100: vector of maskable line 0.
- VEC_STRIDE, 32'h0000_0010: address spacing between maskable vectors.
- NMI_VECTOR, 32'h0000_0080: vector of the non-maskable source.
- MASK_RESET, all ones: mask value at reset (1 = masked).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  NUM_IRQ  maskable request lines, rising-edge sensitive.
- nmi_in  in  1  non-maskable request line, rising-edge sensitive.
- hold_in  in  1  CPU busy/critical section; blocks maskable requests only.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_IRQ  new mask value.
- int_ack  in  1  one-cycle pulse from the control unit when it redirects PC (savePC).
- eoi  in  1  one-cycle pulse when the handler's final instruction is fetched.
- interrupt  out  1  maskable request to the control unit.
- nmint  out  1  non-maskable request to the control unit.
- vector  out  32  handler address for the current request.
- active_id  out  3  index of the selected or in-service maskable line.
- in_service  out  1  a handler is running.
- pending  out  NUM_IRQ  pending maskable bits (debug/status).

Behaviour:
- Reset (async): state=IDLE; pending=0; nmi_pend=0; irq_q=0; nmi_q=0; mask=MASK_RESET; interrupt=0; nmint=0; vector=0; active_id=0; in_service=0.
- Edge detect: irq_q<=irq_in each clock. A rise (irq_in & ~irq_q) sets the pending bit at that same edge. NMI is handled the same way via nmi_q/nmi_pend.
- Set vs clear on the same edge for the same bit: set wins, so the new event is kept.
- Mask: mask_we loads mask at the edge. Masked pending bits stay pending but are not eligible.
- Eligible maskable set = pending & ~mask, considered only when hold_in=0. Priority: lowest index wins.
- States:
  - IDLE → REQ when nmi_pend=1 (select NMI) or the eligible set is non-zero (select lowest index). Selection is latched into sel_nmi/active_id.
  - REQ drives nmint=sel_nmi, interrupt=~sel_nmi, and vector = NMI_VECTOR or IRQ_VEC_BASE + active_id*VEC_STRIDE (32-bit, wrap ignored).
  - REQ, int_ack=1 → SERVICE. Clear nmi_pend or pending[active_id]. Deassert interrupt/nmint. in_service=1. vector holds.
  - REQ with sel_nmi=0, no ack, nmi_pend=1 → stay REQ, reselect NMI (nmint=1, interrupt=0 next cycle).
  - REQ with sel_nmi=0, no ack, and the selected bit becomes masked or hold_in=1 → IDLE, requests dropped. An NMI upgrade takes precedence over withdrawal.
  - SERVICE, eoi=1 → IDLE, in_service=0. New pending events accumulate during SERVICE. Re-arbitration happens at the first IDLE cycle.
- int_ack outside REQ is ignored. eoi outside SERVICE is ignored.
- Ack and NMI rise on the same edge while a maskable request is in REQ: the ack is honoured for the maskable line; the NMI stays pending.
- Latency: irq_in rises before edge k → pending at k → REQ and interrupt=1 after edge k+1 (2 cycles). After eoi, the next eligible request asserts 2 cycles later (IDLE then REQ).
- Outputs are registered; no combinational path from inputs to interrupt/nmint.
- Reset mid-operation: returns to the reset values immediately and discards all pending events.

Decomposition:
- Shared package: state encoding (IDLE=0, REQ=1, SERVICE=2, 2 bits) and default vector constants.
- One sub-module: irq_priority_enc. Combinational lowest-index-first encoder: input NUM_IRQ vector → valid bit plus 3-bit index.

Test Plan:
- Reset with mask=all ones, write mask=4'b0000, pulse irq_in[2] → pending=4'b0100; interrupt=1 and vector=32'h120 two cycles later; int_ack → interrupt=0, in_service=1, pending=0; eoi → in_service=0.
- irq_in[1] and irq_in[3] rise on the same edge → line 1 served first (vector 32'h110). After its eoi, line 3 is requested (vector 32'h130) 2 cycles later.
- nmi_in rises while in REQ for line 0 (not yet acked) → next cycle nmint=1, interrupt=0, vector=32'h80. After ack and eoi, line 0 is still pending and is then requested.
- Masked irq_in[0] pulse → no request, pending[0]=1. Unmask → interrupt=1 two cycles after the mask write. hold_in=1 during REQ → request withdrawn; NMI is still accepted under hold_in.
- Set/clear collision: during REQ for line 2, int_ack and a fresh irq_in[2] rise on the same edge → pending[2] remains 1 after ack. Stray eoi while in IDLE → no effect.
- Assert rst in SERVICE with nmi_pend=1 → all outputs zero, mask=MASK_RESET, no request after rst is released.
